// File: rtl/vga_sync_generator_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_sync_generator_if : scan position, sync and strobe bundle of the VGA   |
// | timing generator. Revision 1.0                                             |
// +----------------------------------------------------------------------------+
interface vga_sync_generator_if;
    logic [15:0] horizontal_actual_position;
    logic [15:0] vertical_actual_position;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic        pixel_tick;
    logic        frame_start;

    modport master (
        output horizontal_actual_position,
        output vertical_actual_position,
        output hsync,
        output vsync,
        output video_on,
        output pixel_tick,
        output frame_start
    );

    modport slave (
        input horizontal_actual_position,
        input vertical_actual_position,
        input hsync,
        input vsync,
        input video_on,
        input pixel_tick,
        input frame_start
    );
endinterface
`default_nettype wire

// File: rtl/vga_sync_generator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_sync_generator : free-running 640x480@60 scan position / sync source.  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module vga_sync_generator #(
    parameter int CLK_DIV  = 4,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    vga_sync_generator_if.master sync_o
);

    localparam int c_h_total = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int c_v_total = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLK_DIV - 1);
    localparam logic [15:0] c_h_last     = 16'(c_h_total - 1);
    localparam logic [15:0] c_v_last     = 16'(c_v_total - 1);
    localparam logic [15:0] c_h_sync     = 16'(H_SYNC);
    localparam logic [15:0] c_v_sync     = 16'(V_SYNC);
    localparam logic [15:0] c_h_vis_lo   = 16'(H_SYNC + H_BP);
    localparam logic [15:0] c_h_vis_hi   = 16'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [15:0] c_v_vis_lo   = 16'(V_SYNC + V_BP);
    localparam logic [15:0] c_v_vis_hi   = 16'(V_SYNC + V_BP + V_ACTIVE);

    logic [DIV_W-1:0] div_q, div_d;
    logic [15:0]      h_q, h_d;
    logic [15:0]      v_q, v_d;
    logic             hsync_q, vsync_q, video_on_q, pixel_tick_q, frame_start_q;
    logic             w_tick, w_h_wrap, w_v_wrap;

    // With CLK_DIV == 1 the divider is a single bit stuck at zero, so the tick is always true.
    assign w_tick = (div_q == c_div_last);

    always_comb begin
        div_d    = w_tick ? '0 : div_q + DIV_W'(1);
        w_h_wrap = w_tick && (h_q == c_h_last);
        w_v_wrap = w_h_wrap && (v_q == c_v_last);
        h_d      = h_q;
        v_d      = v_q;
        if (w_tick) begin
            h_d = w_h_wrap ? 16'd0 : h_q + 16'd1;
        end
        if (w_h_wrap) begin
            v_d = w_v_wrap ? 16'd0 : v_q + 16'd1;
        end
    end

    // Decodes use next-state counters so they land on the same edge as the position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            h_q           <= 16'd0;
            v_q           <= 16'd0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            video_on_q    <= 1'b0;
            pixel_tick_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= (h_d >= c_h_sync);
            vsync_q       <= (v_d >= c_v_sync);
            video_on_q    <= (h_d >= c_h_vis_lo) && (h_d < c_h_vis_hi) &&
                             (v_d >= c_v_vis_lo) && (v_d < c_v_vis_hi);
            pixel_tick_q  <= (div_d == c_div_last);
            frame_start_q <= w_v_wrap;
        end
    end

    assign sync_o.horizontal_actual_position = h_q;
    assign sync_o.vertical_actual_position   = v_q;
    assign sync_o.hsync                      = hsync_q;
    assign sync_o.vsync                      = vsync_q;
    assign sync_o.video_on                   = video_on_q;
    assign sync_o.pixel_tick                 = pixel_tick_q;
    assign sync_o.frame_start                = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_generator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vga_sync_generator : three generators (default, divide-by-1, reduced    |
// | raster) compared every cycle to an arithmetic scan model. Revision 1.0     |
// +----------------------------------------------------------------------------+
module tb_vga_sync_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    logic rst_c_n = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int cyc_rel = 0;
    int n_a = 0, n_b = 0, n_c = 0;

    always @(posedge clk) cyc <= cyc + 1;

    vga_sync_generator_if if_a ();
    vga_sync_generator_if if_b ();
    vga_sync_generator_if if_c ();

    vga_sync_generator #(.CLK_DIV(4)) dut_a (.clk(clk), .rst_n(rst_a_n), .sync_o(if_a));
    vga_sync_generator #(.CLK_DIV(1)) dut_b (.clk(clk), .rst_n(rst_b_n), .sync_o(if_b));
    vga_sync_generator #(
        .CLK_DIV(2), .H_SYNC(4), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(2), .V_BP(3), .V_ACTIVE(5), .V_FP(2)
    ) dut_c (.clk(clk), .rst_n(rst_c_n), .sync_o(if_c));

    // Clock edges seen since reset release, per generator.
    always @(posedge clk or negedge rst_a_n) if (!rst_a_n) n_a <= 0; else n_a <= n_a + 1;
    always @(posedge clk or negedge rst_b_n) if (!rst_b_n) n_b <= 0; else n_b <= n_b + 1;
    always @(posedge clk or negedge rst_c_n) if (!rst_c_n) n_c <= 0; else n_c <= n_c + 1;

    // Output after n edges: {h, v, hsync, vsync, video_on, pixel_tick, frame_start}.
    function automatic logic [36:0] exp_out(int n, int d, int hs, int hb, int ha, int hf,
                                            int vs, int vb, int va, int vf);
        int ht, vt, p, h, v;
        logic s_h, s_v, vo, pt, fs;
        ht  = hs + hb + ha + hf;
        vt  = vs + vb + va + vf;
        p   = n / d;
        h   = p % ht;
        v   = (p / ht) % vt;
        s_h = (h >= hs);
        s_v = (v >= vs);
        vo  = (h >= hs + hb) && (h < hs + hb + ha) && (v >= vs + vb) && (v < vs + vb + va);
        pt  = (n > 0) && (((n + 1) % d) == 0);
        fs  = (n > 0) && ((n % (d * ht * vt)) == 0);
        return {16'(h), 16'(v), s_h, s_v, vo, pt, fs};
    endfunction

    function automatic logic [36:0] exp_def(int n);
        return exp_out(n, 4, 96, 48, 640, 16, 2, 33, 480, 10);
    endfunction

    function automatic logic [36:0] got(int which);
        case (which)
            0: return {if_a.horizontal_actual_position, if_a.vertical_actual_position,
                       if_a.hsync, if_a.vsync, if_a.video_on, if_a.pixel_tick, if_a.frame_start};
            1: return {if_b.horizontal_actual_position, if_b.vertical_actual_position,
                       if_b.hsync, if_b.vsync, if_b.video_on, if_b.pixel_tick, if_b.frame_start};
            default: return {if_c.horizontal_actual_position, if_c.vertical_actual_position,
                       if_c.hsync, if_c.vsync, if_c.video_on, if_c.pixel_tick, if_c.frame_start};
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Bounded wait for a DUT to reach position (h,v), sampled on falling edges.
    task automatic wait_pos(input int which, input int h, input int v, input int limit);
        logic [36:0] g;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            g = got(which);
            if (g[36:21] == 16'(h) && g[20:5] == 16'(v)) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_pos dut%0d: actual timeout required (%0d,%0d)", which, h, v);
    endtask

    always @(negedge clk) begin
        chk("model_a", 64'(got(0)), 64'(exp_def(n_a)));
        chk("model_b", 64'(got(1)), 64'(exp_out(n_b, 1, 96, 48, 640, 16, 2, 33, 480, 10)));
        chk("model_c", 64'(got(2)), 64'(exp_out(n_c, 2, 4, 3, 8, 2, 2, 3, 5, 2)));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual still running required finished");
        $fatal(1, "watchdog");
    end

    // Reduced-raster window is h 7..14, v 5..9; entries are in scan order.
    int c_h [8] = '{7, 6, 7, 14, 15, 7, 14, 7};
    int c_v [8] = '{4, 5, 5, 5, 5, 9, 9, 10};
    bit c_vo[8] = '{0, 0, 1, 1, 0, 1, 1, 0};

    initial begin
        // Model pins for the default 640x480 window and frame length.
        chk("pin_vo_144_35",  64'(exp_def(4 * (35 * 800 + 144))  >> 2 & 1), 64'd1);
        chk("pin_vo_143_35",  64'(exp_def(4 * (35 * 800 + 143))  >> 2 & 1), 64'd0);
        chk("pin_vo_783_514", 64'(exp_def(4 * (514 * 800 + 783)) >> 2 & 1), 64'd1);
        chk("pin_vo_784_35",  64'(exp_def(4 * (35 * 800 + 784))  >> 2 & 1), 64'd0);
        chk("pin_vo_144_34",  64'(exp_def(4 * (34 * 800 + 144))  >> 2 & 1), 64'd0);
        chk("pin_vo_144_515", 64'(exp_def(4 * (515 * 800 + 144)) >> 2 & 1), 64'd0);
        chk("pin_fs_frame",   64'(exp_def(1680000) & 1), 64'd1);

        repeat (3) @(negedge clk);
        chk("reset_a", 64'(got(0)), 64'd0);
        chk("reset_c", 64'(got(2)), 64'd0);
        #2;
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        rst_c_n = 1'b1;
        cyc_rel = cyc;

        fork
            begin : thr_a
                logic [36:0] g;
                repeat (3) @(negedge clk);
                g = got(0);
                chk("tick_before_adv_a", {g[1], g[36:21]}, {1'b1, 16'd0});
                @(negedge clk);
                g = got(0);
                chk("first_adv_a", {g[1], g[36:21]}, {1'b0, 16'd1});
                wait_pos(0, 95, 0, 400);
                chk("hsync_h95_a", 64'(if_a.hsync), 64'd0);
                wait_pos(0, 96, 0, 8);
                chk("hsync_h96_a", 64'(if_a.hsync), 64'd1);
                wait_pos(0, 799, 0, 3000);
                wait_pos(0, 0, 1, 8);
                chk("line_clks_a", 64'(cyc - cyc_rel), 64'd3200);
            end
            begin : thr_b
                wait_pos(1, 799, 0, 900);
                @(negedge clk);
                g_b_check();
            end
            begin : thr_c
                int t1;
                for (int i = 0; i < 8; i++) begin
                    wait_pos(2, c_h[i], c_v[i], 450);
                    chk($sformatf("corner_c_%0d_%0d", c_h[i], c_v[i]),
                        64'(if_c.video_on), 64'(c_vo[i]));
                end
                wait_fs_c(500);
                t1 = cyc;
                chk("first_fs_c", 64'(cyc - cyc_rel), 64'd408);
                chk("fs_pos_c", {if_c.horizontal_actual_position, if_c.vertical_actual_position}, 64'd0);
                @(negedge clk);
                wait_fs_c(500);
                chk("frame_clks_c", 64'(cyc - t1), 64'd408);
                wait_pos(2, 10, 6, 500);
                #2;
                rst_c_n = 1'b0;
                #1;
                chk("midreset_async_c", 64'(got(2)), 64'd0);
                repeat (2) @(negedge clk);
                #2;
                rst_c_n = 1'b1;
                t1 = cyc;
                @(negedge clk);
                chk("restart_pos_c", {if_c.horizontal_actual_position, if_c.vertical_actual_position}, 64'd0);
                wait_fs_c(500);
                chk("restart_fs_c", 64'(cyc - t1), 64'd408);
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic g_b_check();
        chk("wrap_b", {if_b.horizontal_actual_position, if_b.vertical_actual_position},
            {32'd0, 16'd0, 16'd1});
        chk("line_clks_b", 64'(cyc - cyc_rel), 64'd800);
        chk("tick_const_b", 64'(if_b.pixel_tick), 64'd1);
    endtask

    task automatic wait_fs_c(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (if_c.frame_start) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_fs_c: actual timeout required frame_start pulse");
    endtask

endmodule
`default_nettype wire
